// File: rtl/tlb_refill_ctrl.sv
// TLB refill controller: converts a TLB miss into a single PTW request and
// returns exactly one refill (vpn, ppn, fault) per accepted miss. Handles
// sfence kills, PTW backpressure, walk timeout and discarding of orphaned
// (late or killed) walk responses. Only one miss is ever in flight.
module tlb_refill_ctrl #(
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 20,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [VPN_W-1:0] io_req_bits_vpn,
  input  logic             io_tlb_hit,
  input  logic             io_sfence_valid,
  output logic             io_ptw_req_valid,
  input  logic             io_ptw_req_ready,
  output logic [VPN_W-1:0] io_ptw_req_bits_vpn,
  input  logic             io_ptw_resp_valid,
  input  logic [PPN_W-1:0] io_ptw_resp_bits_pte_ppn,
  input  logic             io_ptw_resp_bits_error,
  output logic             io_refill_valid,
  output logic [VPN_W-1:0] io_refill_vpn,
  output logic [PPN_W-1:0] io_refill_ppn,
  output logic             io_refill_fault,
  output logic             io_miss_busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    WAIT    = 3'd2,
    REFILL  = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic [PPN_W-1:0] ppn_q, ppn_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out_q, timed_out_d;

  // State and miss-context registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vpn_q       <= '0;
      ppn_q       <= '0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vpn_q       <= vpn_d;
      ppn_q       <= ppn_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Next-state, context updates and Moore outputs.
  always_comb begin
    state_d     = state_q;
    vpn_d       = vpn_q;
    ppn_d       = ppn_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;

    io_req_ready        = 1'b0;
    io_ptw_req_valid    = 1'b0;
    io_refill_valid     = 1'b0;
    io_miss_busy        = 1'b1;
    io_ptw_req_bits_vpn = vpn_q;
    io_refill_vpn       = vpn_q;
    io_refill_ppn       = ppn_q;
    io_refill_fault     = fault_q;

    case (state_q)
      IDLE: begin
        io_req_ready = 1'b1;
        io_miss_busy = 1'b0;
        timed_out_d  = 1'b0;
        // Hits and requests racing a flush never start a walk.
        if (io_req_valid && !io_tlb_hit && !io_sfence_valid) begin
          vpn_d   = io_req_bits_vpn;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        io_ptw_req_valid = 1'b1;
        if (io_ptw_req_ready) begin
          cnt_d       = '0;
          timed_out_d = 1'b0;
          // A walk already handed to the PTW must have its response drained.
          state_d     = io_sfence_valid ? DRAIN : WAIT;
        end else if (io_sfence_valid) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (io_ptw_resp_valid) begin
          // A response in the timeout cycle still counts as a normal response.
          if (io_sfence_valid) begin
            state_d = IDLE;
          end else begin
            ppn_d   = io_ptw_resp_bits_pte_ppn;
            fault_d = io_ptw_resp_bits_error;
            state_d = REFILL;
          end
        end else if (io_sfence_valid) begin
          state_d = DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          ppn_d       = '0;
          fault_d     = 1'b1;
          timed_out_d = 1'b1;
          state_d     = REFILL;
        end
      end
      REFILL: begin
        io_refill_valid = 1'b1;
        // After a timeout the walk is still outstanding; its response is dropped.
        state_d = timed_out_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (io_ptw_resp_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/tlb_refill_ctrl.md
TLB_REFILL_CTRL -- requirements
Module: tlb_refill_ctrl

Sits directly upstream of the address-protection check. It turns TLB misses into PTW requests and delivers exactly one validated refill (vpn, ppn) per miss.

Interface
REQ-001 The block SHALL have parameter VPN_W, default 20, virtual page number width.
REQ-002 The block SHALL have parameter PPN_W, default 20, physical page number width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, maximum cycles spent in WAIT before a fault; legal range 2..1023.
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port rst_n, input, 1; one clock, reset asynchronous and active-low.
REQ-006 The block SHALL have port io_req_valid, input, 1, translation request.
REQ-007 The block SHALL have port io_req_ready, output, 1, request accepted.
REQ-008 The block SHALL have port io_req_bits_vpn, input, VPN_W, request VPN.
REQ-009 The block SHALL have port io_tlb_hit, input, 1, same-cycle tag-compare hit for io_req_bits_vpn.
REQ-010 The block SHALL have port io_sfence_valid, input, 1, flush/kill of any miss in flight.
REQ-011 The block SHALL have port io_ptw_req_valid, output, 1, PTW request.
REQ-012 The block SHALL have port io_ptw_req_ready, input, 1, PTW accepts the request.
REQ-013 The block SHALL have port io_ptw_req_bits_vpn, output, VPN_W, VPN sent to the PTW.
REQ-014 The block SHALL have port io_ptw_resp_valid, input, 1, PTW response, single-cycle pulse.
REQ-015 The block SHALL have port io_ptw_resp_bits_pte_ppn, input, PPN_W, returned PPN.
REQ-016 The block SHALL have port io_ptw_resp_bits_error, input, 1, page-walk error.
REQ-017 The block SHALL have port io_refill_valid, output, 1, one-cycle refill strobe to the protection check and TLB array.
REQ-018 The block SHALL have port io_refill_vpn, output, VPN_W, refill VPN.
REQ-019 The block SHALL have port io_refill_ppn, output, PPN_W, refill PPN.
REQ-020 The block SHALL have port io_refill_fault, output, 1, refill carries a walk error or timeout; qualified by io_refill_valid.
REQ-021 The block SHALL have port io_miss_busy, output, 1, asserted in every state except IDLE.

Function
REQ-022 The FSM SHALL have exactly the states IDLE, REQUEST, WAIT, REFILL and DRAIN, held in registered state.
REQ-023 In IDLE, io_req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-024 In IDLE, when io_req_valid=1, io_tlb_hit=0 and io_sfence_valid=0, the block SHALL latch io_req_bits_vpn into vpn_q and move to REQUEST on the next edge.
REQ-025 In IDLE, a request with io_tlb_hit=1, or any request while io_sfence_valid=1, SHALL leave the state in IDLE and latch nothing.
REQ-026 In REQUEST, io_ptw_req_valid SHALL be 1 and io_ptw_req_bits_vpn SHALL equal vpn_q; the block SHALL hold both stable until io_ptw_req_ready=1.
REQ-027 On the REQUEST handshake, the block SHALL move to WAIT and clear the timeout counter to 0.
REQ-028 A REQUEST handshake coinciding with io_sfence_valid SHALL take the block to DRAIN, because the walk is already issued.
REQ-029 io_sfence_valid in REQUEST without a handshake SHALL return the block to IDLE and issue no PTW request.
REQ-030 In WAIT, the counter SHALL increment by 1 per cycle, saturating at TIMEOUT.
REQ-031 In WAIT, io_ptw_resp_valid=1 with io_sfence_valid=0 SHALL latch ppn_q from io_ptw_resp_bits_pte_ppn, latch fault_q from io_ptw_resp_bits_error, and move the block to REFILL.
REQ-032 In WAIT, io_ptw_resp_valid=1 together with io_sfence_valid=1 SHALL discard the response and move the block to IDLE.
REQ-033 In WAIT, io_sfence_valid=1 without a response SHALL move the block to DRAIN.
REQ-034 When the counter equals TIMEOUT-1 in WAIT and no response arrives, the block SHALL set ppn_q to 0 and fault_q to 1, and move to REFILL.
REQ-035 A timed-out miss SHALL be marked so that REFILL exits to DRAIN instead of IDLE, because the late response must be discarded.
REQ-036 A response arriving in the same cycle as the timeout SHALL win, and the walk SHALL not be treated as timed out.
REQ-037 In REFILL, io_refill_valid SHALL be 1 for exactly one cycle, with io_refill_vpn=vpn_q, io_refill_ppn=ppn_q and io_refill_fault=fault_q.
REQ-038 io_sfence_valid in REFILL SHALL not suppress the strobe.
REQ-039 In DRAIN, the block SHALL ignore io_sfence_valid and move to IDLE on io_ptw_resp_valid=1 without producing any refill.
REQ-040 io_ptw_resp_valid in IDLE or REQUEST SHALL be ignored.
REQ-041 Latency from the PTW response to io_refill_valid SHALL be exactly 1 cycle.
REQ-042 The minimum miss-to-refill time SHALL be 3 cycles after request acceptance, with the PTW ready and responding the cycle after the request handshake.
REQ-043 At most one miss SHALL be in flight at any time.

Reset
REQ-044 Asserting rst_n=0 SHALL immediately and asynchronously force state=IDLE, vpn_q=0, ppn_q=0, fault_q=0, the counter to 0 and the timed-out flag to 0.
REQ-045 While rst_n=0, outputs SHALL be io_req_ready=1, io_miss_busy=0, io_ptw_req_valid=0, io_refill_valid=0, io_refill_fault=0, io_refill_vpn=0, io_refill_ppn=0, io_ptw_req_bits_vpn=0.
REQ-046 A PTW response arriving after a mid-walk reset SHALL be ignored in IDLE.

Verification
REQ-047 The bench SHALL cover a basic miss: vpn=0x80000, hit=0, ptw ready at once, response ppn=0x80001 two cycles later -> one refill strobe with vpn=0x80000, ppn=0x80001, fault=0, then IDLE.
REQ-048 The bench SHALL cover a hit: req_valid=1, hit=1 -> no io_ptw_req_valid, state stays IDLE, busy=0.
REQ-049 The bench SHALL cover backpressure: ptw_req_ready low for 5 cycles -> io_ptw_req_valid and vpn stay stable, handshake on cycle 6, then normal refill.
REQ-050 The bench SHALL cover a flush mid-walk: sfence in WAIT, response 10 cycles later -> no refill strobe, IDLE after the response, next miss served correctly.
REQ-051 The bench SHALL cover a timeout with TIMEOUT=8: no response -> refill strobe with fault=1 and ppn=0 after 8 WAIT cycles, DRAIN; a late response produces no strobe, then IDLE.
REQ-052 The bench SHALL cover reset mid-WAIT: rst_n pulsed low -> outputs at reset values in the same cycle; a later response is ignored.
